// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter FSM state type.
// Imported by AHB arbiters and their helper blocks.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b010;
  localparam logic [2:0] HBURST_WRAP4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b100;
  localparam logic [2:0] HBURST_WRAP8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b110;
  localparam logic [2:0] HBURST_WRAP16 = 3'b111;

  localparam int unsigned BEAT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SINGLE    = 2'd1,
    ST_BURST_FIX = 2'd2,
    ST_BURST_INC = 2'd3
  } arb_state_e;

  // Beats remaining after the NONSEQ of a fixed-length burst.
  function automatic logic [BEAT_CNT_W-1:0] burst_last_beat(input logic [2:0] hburst);
    case (hburst)
      HBURST_INCR4, HBURST_WRAP4:   return BEAT_CNT_W'(3);
      HBURST_INCR8, HBURST_WRAP8:   return BEAT_CNT_W'(7);
      HBURST_INCR16, HBURST_WRAP16: return BEAT_CNT_W'(15);
      default:                      return '0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational, reusable by any arbiter.
module rr_pick #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         winner
);

  localparam int unsigned PW = $clog2(N);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB slave-port round-robin arbiter: grants one master at a time and
// holds ownership across SINGLE, fixed-length and INCR bursts.
module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned HMAS_NUM     = 5,
  parameter int unsigned HBURST_WIDTH = 3
) (
  input  logic                        hclk,
  input  logic                        hresetn,
  input  logic [HMAS_NUM-1:0]         req_m,
  input  logic [1:0]                  htrans_m [0:HMAS_NUM-1],
  input  logic [HBURST_WIDTH-1:0]     hburst_m [0:HMAS_NUM-1],
  input  logic                        hready,
  input  logic                        hresp,
  output logic [HMAS_NUM-1:0]         grant,
  output logic [HMAS_NUM-1:0]         grant_dphase,
  output logic [$clog2(HMAS_NUM)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(HMAS_NUM);

  arb_state_e            state, state_nxt;
  logic [HMAS_NUM-1:0]   grant_nxt, dphase_nxt, win;
  logic [IDX_W-1:0]      rr_ptr, ptr_nxt, win_idx;
  logic [BEAT_CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]            own_trans;
  logic [2:0]            own_burst;
  logic                  has_owner, rel;

  rr_pick #(.N(HMAS_NUM)) u_rr_pick (
    .req    (req_m),
    .ptr    (rr_ptr),
    .winner (win)
  );

  // One-hot to binary for the current grant and the pending winner.
  always_comb begin
    grant_idx = '0;
    win_idx   = '0;
    for (int i = 0; i < HMAS_NUM; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
      if (win[i])   win_idx   = IDX_W'(i);
    end
  end

  assign has_owner = |grant;
  assign own_trans = htrans_m[grant_idx];
  assign own_burst = 3'(hburst_m[grant_idx]);

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state        <= ST_IDLE;
      grant        <= '0;
      grant_dphase <= '0;
      rr_ptr       <= '0;
      cnt          <= '0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      grant_dphase <= dphase_nxt;
      rr_ptr       <= ptr_nxt;
      cnt          <= cnt_nxt;
    end
  end

  // Release detection and re-arbitration; everything holds while hready=0.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    dphase_nxt = grant_dphase;
    ptr_nxt    = rr_ptr;
    cnt_nxt    = cnt;
    rel        = 1'b0;

    if (hready) begin
      dphase_nxt = (has_owner && own_trans[1]) ? grant : '0;

      case (state)
        ST_IDLE: rel = 1'b1;
        ST_SINGLE: begin
          if (own_trans == HTRANS_IDLE) begin
            rel = 1'b1;
          end else if (own_trans == HTRANS_NONSEQ) begin
            case (own_burst)
              HBURST_SINGLE: rel = 1'b1;
              HBURST_INCR:   state_nxt = ST_BURST_INC;
              default: begin
                state_nxt = ST_BURST_FIX;
                cnt_nxt   = burst_last_beat(own_burst);
              end
            endcase
          end
        end
        ST_BURST_FIX: begin
          if (own_trans == HTRANS_IDLE) begin
            rel = 1'b1;
          end else if (own_trans == HTRANS_SEQ) begin
            if (cnt == BEAT_CNT_W'(1)) rel = 1'b1;
            else                       cnt_nxt = cnt - BEAT_CNT_W'(1);
          end
        end
        ST_BURST_INC: begin
          case (own_trans)
            HTRANS_IDLE, HTRANS_NONSEQ: rel = 1'b1;
            HTRANS_BUSY, HTRANS_SEQ:    rel = 1'b0;
            default:                    rel = 1'b0;
          endcase
        end
        default: rel = 1'b1;
      endcase

      if (hresp) rel = 1'b1;

      if (rel) begin
        grant_nxt = win;
        cnt_nxt   = '0;
        if (|req_m) begin
          state_nxt = ST_SINGLE;
          ptr_nxt   = (win_idx == IDX_W'(HMAS_NUM - 1)) ? '0 : win_idx + IDX_W'(1);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level ownership model.
module tb_ahb_rr_arbiter;

  localparam int N = 5;

  logic         hclk = 1'b0;
  logic         hresetn;
  logic [N-1:0] req_m;
  logic [1:0]   htrans_m [0:N-1];
  logic [2:0]   hburst_m [0:N-1];
  logic         hready;
  logic         hresp;
  logic [N-1:0] grant;
  logic [N-1:0] grant_dphase;
  logic [2:0]   grant_idx;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner/data-phase owner as master numbers (-1 = none).
  int m_owner = -1;
  int m_dph   = -1;
  int m_mode  = 0;   // 0 none, 1 awaiting first NONSEQ, 2 fixed burst, 3 INCR
  int m_left  = 0;   // SEQ beats still owed in a fixed burst
  int m_ptr   = 0;

  ahb_rr_arbiter #(.HMAS_NUM(N), .HBURST_WIDTH(3)) dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .req_m        (req_m),
    .htrans_m     (htrans_m),
    .hburst_m     (hburst_m),
    .hready       (hready),
    .hresp        (hresp),
    .grant        (grant),
    .grant_dphase (grant_dphase),
    .grant_idx    (grant_idx)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int m);
    logic [N-1:0] v;
    v = '0;
    if (m >= 0) v = N'(1) << m;
    return v;
  endfunction

  task automatic model_step();
    int  tr, hb, c;
    bit  rel;
    if (!hresetn) begin
      m_owner = -1; m_dph = -1; m_mode = 0; m_left = 0; m_ptr = 0;
      return;
    end
    if (!hready) return;
    tr    = (m_owner >= 0) ? int'(htrans_m[3'(m_owner)]) : 0;
    m_dph = (m_owner >= 0 && tr >= 2) ? m_owner : -1;
    rel   = (m_owner < 0) || (tr == 0) || (hresp == 1'b1);
    if (!rel) begin
      case (m_mode)
        1: if (tr == 2) begin
             hb = int'(hburst_m[3'(m_owner)]);
             if (hb == 0)      rel = 1'b1;
             else if (hb == 1) m_mode = 3;
             else begin
               m_mode = 2;
               m_left = (4 << ((hb - 2) / 2)) - 1;
             end
           end
        2: if (tr == 3) begin
             m_left--;
             rel = (m_left == 0);
           end
        3: rel = (tr == 2);
        default: ;
      endcase
    end
    if (rel) begin
      m_owner = -1;
      m_mode  = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (m_owner < 0 && req_m[3'(c)]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_ptr  = (m_owner + 1) % N;
        m_mode = 1;
      end
    end
  endtask

  task automatic check_model();
    chk("grant",  32'(grant),        32'(oh(m_owner)));
    chk("gidx",   32'(grant_idx),    (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("dphase", 32'(grant_dphase), 32'(oh(m_dph)));
  endtask

  task automatic tick();
    model_step();
    @(posedge hclk);
    @(negedge hclk);
    check_model();
  endtask

  task automatic set_all(input logic [1:0] tr, input logic [2:0] hb);
    for (int i = 0; i < N; i++) begin
      htrans_m[i] = tr;
      hburst_m[i] = hb;
    end
  endtask

  task automatic rand_inputs();
    int r;
    hresetn = ($urandom_range(0, 199) != 0);
    req_m   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 9);
      htrans_m[i] = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 5) ? 2'b10 : 2'b11;
      hburst_m[i] = 3'($urandom);
    end
    hready = ($urandom_range(0, 4) != 0);
    hresp  = ($urandom_range(0, 29) == 0);
  endtask

  localparam logic [N-1:0] RR_EXP [0:3] = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
  localparam logic [1:0]   B4_TR  [0:6] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
  localparam logic         B4_RDY [0:6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [N-1:0] B4_EXP [0:6] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010,
                                            5'b00010, 5'b00010, 5'b01000};

  initial begin
    hresetn = 1'b0; req_m = 5'b11111; hready = 1'b1; hresp = 1'b0;
    set_all(2'b10, 3'b000);

    // Reset held two cycles with every master requesting.
    tick(); tick();
    chk("rst_grant",  32'(grant),        32'd0);
    chk("rst_dphase", 32'(grant_dphase), 32'd0);
    hresetn = 1'b1;
    tick();
    chk("first_grant", 32'(grant), 32'(5'b00001));

    // Round-robin over masters 0, 2, 4.
    hresetn = 1'b0; tick(); hresetn = 1'b1;
    req_m = 5'b10101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_seq", 32'(grant), 32'(RR_EXP[i]));
    end

    // INCR4 by master 1 with two wait states on beat 2, master 3 waiting.
    hresetn = 1'b0; tick(); hresetn = 1'b1;
    req_m = 5'b01010;
    for (int i = 0; i < 7; i++) begin
      set_all(B4_TR[i], 3'b010);
      hready = B4_RDY[i];
      tick();
      chk("incr4", 32'(grant), 32'(B4_EXP[i]));
    end
    hready = 1'b1;

    // Reset landing on beat 5 of an INCR16 clears everything, pointer included.
    hresetn = 1'b0; tick(); hresetn = 1'b1;
    req_m = 5'b00010;
    set_all(2'b10, 3'b110);
    tick(); tick();
    set_all(2'b11, 3'b110);
    tick(); tick(); tick();
    chk("b16_hold", 32'(grant), 32'(5'b00010));
    hresetn = 1'b0;
    tick();
    chk("midrst_grant",  32'(grant),        32'd0);
    chk("midrst_dphase", 32'(grant_dphase), 32'd0);
    chk("midrst_idx",    32'(grant_idx),    32'd0);
    hresetn = 1'b1; req_m = 5'b00011;
    set_all(2'b10, 3'b000);
    tick();
    chk("midrst_ptr", 32'(grant), 32'(5'b00001));

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rand_inputs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
